pipelined_multiplier_v2: RTL
============================

PIPELINED_MULTIPLIER_V2 -- requirements
Module: pipelined_multiplier_v2

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter PIPELINE_STAGE, default 2: accept-to-result latency in cycles, legal range 1..8.
REQ-003 SHALL have parameter TAG_LEN, default 8: width of the opaque tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: drops every in-flight operation.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1): input handshake.
REQ-008 SHALL have ports a and b, input, DATA_LEN bits each: operands.
REQ-009 SHALL have port in_signed, input, 1 bit: 1 = two's-complement multiply, 0 = unsigned multiply.
REQ-010 SHALL have port in_tag, input, TAG_LEN bits: passed through unchanged with the operation.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1): output handshake.
REQ-012 SHALL have port result, output, 2*DATA_LEN bits: full-width product.
REQ-013 SHALL have port out_tag, output, TAG_LEN bits: tag of the current result.
REQ-014 SHALL have port overflow, output, 1 bit: product does not fit in DATA_LEN bits (see REQ-027).
REQ-015 SHALL have port inflight, output, $clog2(PIPELINE_STAGE+1) bits: count of valid pipeline entries.

Function
REQ-016 SHALL accept an operation on a cycle where in_valid && in_ready.
REQ-017 SHALL carry a valid/tag/sign shift register of depth PIPELINE_STAGE, parallel to the datapath; completion is tracked by these valid bits, not by a cycle counter.
REQ-018 SHALL assert out_valid exactly PIPELINE_STAGE cycles after acceptance when no stall occurs.
REQ-019 SHALL define stall = out_valid && !out_ready; while stall is 1, every stage holds its contents and result/out_tag/overflow stay stable.
REQ-020 SHALL drive in_ready = !stall && !flush, combinationally.
REQ-021 SHALL sustain one accepted operation per cycle when out_ready is held at 1.
REQ-022 SHALL preserve order: results leave in acceptance order, with no drop or duplication except on flush/reset.
REQ-023 SHALL produce result = a*b, with operands sign-extended to 2*DATA_LEN when in_signed=1 and zero-extended otherwise.
REQ-024 SHALL clear all valid bits on the next edge when flush=1, regardless of stall; data registers may keep stale values; inflight reads 0 on the following cycle.
REQ-025 SHALL update inflight by +1 per accept and -1 per output handshake (both in one cycle = unchanged).
REQ-026 SHALL drive result/out_tag/overflow as don't-care when out_valid=0; the bench checks them only when out_valid=1.

Configuration
REQ-027 SHALL compile overflow detection in when MULTIPLIER_OVERFLOW_FLAG_EN is defined:
- unsigned: overflow=1 iff result[2*DATA_LEN-1:DATA_LEN] != 0
- signed: overflow=1 iff the upper DATA_LEN+1 bits of result are not all equal
- the flag is registered through the same stages as the result.
REQ-028 SHALL tie overflow to constant 0 and instantiate no detection logic when MULTIPLIER_OVERFLOW_FLAG_EN is undefined; all other behaviour is unchanged.

Reset
REQ-029 SHALL, on reset=1, synchronously clear all valid bits, set out_valid=0 and inflight=0; in_ready is 1 while reset is deasserted and no stall exists.
REQ-030 SHALL discard any operation in flight when reset is asserted mid-operation; no output handshake occurs on the reset cycle or the cycle after it.
REQ-031 SHALL give reset priority over flush, and flush priority over accept in the same cycle.

Verification
REQ-032 SHALL cover: DATA_LEN=32, PIPELINE_STAGE=2, unsigned a=7, b=6, tag=0x11, out_ready=1 -> out_valid 2 cycles later, result=42, out_tag=0x11, overflow=0.
REQ-033 SHALL cover: signed a=0xFFFFFFFF (-1), b=5 -> result=0xFFFFFFFFFFFFFFFB; the same operands unsigned -> result=0x00000004FFFFFFFB, overflow=1 with the macro defined and 0 without it.
REQ-034 SHALL cover: back-to-back tags 1,2,3,4 with out_ready=1 -> four consecutive out_valid cycles in tag order, inflight peaks at 2.
REQ-035 SHALL cover: out_ready=0 for 5 cycles while issuing 3 ops -> in_ready drops once the first result is presented, outputs stay stable, and all 3 results drain in order after release.
REQ-036 SHALL cover: flush asserted 1 cycle after accepting tag 0x22 -> out_valid never rises for 0x22, inflight=0, and the next op completes normally.
REQ-037 SHALL cover: reset asserted with 2 ops in flight -> out_valid=0 and inflight=0 on the next cycle, with no stale result emitted afterwards.

Source files
------------

// File: rtl/pipelined_multiplier_v2.sv
// Pipelined signed/unsigned multiplier with valid/ready handshakes, flush, and a tag carried per operation.
// Define MULTIPLIER_OVERFLOW_FLAG_EN to build in overflow detection; without it, overflow is tied to 0.
module pipelined_multiplier_v2 #(
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 2,
   parameter int TAG_LEN        = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [DATA_LEN-1:0]                  a,
   input  logic [DATA_LEN-1:0]                  b,
   input  logic                                 in_signed,
   input  logic [TAG_LEN-1:0]                   in_tag,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [2*DATA_LEN-1:0]                result,
   output logic [TAG_LEN-1:0]                   out_tag,
   output logic                                 overflow,
   output logic [$clog2(PIPELINE_STAGE+1)-1:0]  inflight
);

   localparam int PROD_W = 2 * DATA_LEN;
   localparam int CNT_W  = $clog2(PIPELINE_STAGE + 1);
   localparam int LAST   = PIPELINE_STAGE - 1;
   localparam logic [DATA_LEN-1:0] ZERO_D  = {DATA_LEN{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1'b1);

   typedef logic [PIPELINE_STAGE-1:0]              bit_arr_t;
   typedef logic [PIPELINE_STAGE-1:0][TAG_LEN-1:0] tag_arr_t;
   typedef logic [PIPELINE_STAGE-1:0][PROD_W-1:0]  prod_arr_t;
   typedef logic [PIPELINE_STAGE-1:0][DATA_LEN-1:0] corr_arr_t;

   bit_arr_t          valid_r;
   bit_arr_t          sign_r;
   tag_arr_t          tag_r;
   prod_arr_t         prod_r;
   corr_arr_t         corr_r;
   logic [CNT_W-1:0]  inflight_r;

   bit_arr_t          valid_next_s;
   bit_arr_t          sign_next_s;
   tag_arr_t          tag_next_s;
   prod_arr_t         prod_next_s;
   corr_arr_t         corr_next_s;

   logic [PROD_W-1:0]   in_prod_s;
   logic [DATA_LEN-1:0] in_corr_s;
   logic [DATA_LEN-1:0] out_corr_s;
   logic                valid_out_s;
   logic                stall_s;
   logic                accept_s;
   logic                out_fire_s;

   // Unsigned partial product plus the upper-half term that turns it into a two's-complement product.
   always_comb begin
      in_prod_s = {ZERO_D, a} * {ZERO_D, b};
      in_corr_s = (a[DATA_LEN-1] ? b : ZERO_D) + (b[DATA_LEN-1] ? a : ZERO_D);
   end

   // Reset masks the output immediately so nothing can be handed off on the reset cycle.
   assign valid_out_s = valid_r[LAST] & ~reset;
   assign stall_s     = valid_out_s & ~out_ready;
   assign in_ready    = ~stall_s & ~flush;
   assign accept_s    = in_valid & in_ready;
   assign out_fire_s  = valid_out_s & out_ready;

   // Next-stage contents: each stage takes the one below it, stage 0 takes the input.
   always_comb begin
      valid_next_s = bit_arr_t'({valid_r, accept_s});
      sign_next_s  = bit_arr_t'({sign_r, in_signed});
      tag_next_s   = tag_arr_t'({tag_r, in_tag});
      prod_next_s  = prod_arr_t'({prod_r, in_prod_s});
      corr_next_s  = corr_arr_t'({corr_r, in_corr_s});
   end

   // Valid shift register: reset beats flush, flush beats stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= {PIPELINE_STAGE{1'b0}};
      end else if (flush) begin
         valid_r <= {PIPELINE_STAGE{1'b0}};
      end else if (!stall_s) begin
         valid_r <= valid_next_s;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Payload stages advance together and freeze while the output is stalled.
   always_ff @(posedge clk) begin
      if (!stall_s) begin
         sign_r <= sign_next_s;
         tag_r  <= tag_next_s;
         prod_r <= prod_next_s;
         corr_r <= corr_next_s;
      end else begin
         sign_r <= sign_r;
         tag_r  <= tag_r;
         prod_r <= prod_r;
         corr_r <= corr_r;
      end
   end

   // Occupancy counter: +1 per accept, -1 per output handshake.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         inflight_r <= {CNT_W{1'b0}};
      end else begin
         case ({accept_s, out_fire_s})
            2'b10:   inflight_r <= inflight_r + CNT_ONE;
            2'b01:   inflight_r <= inflight_r - CNT_ONE;
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Final stage applies the signed correction to the upper half of the stored product.
   always_comb begin
      out_corr_s = sign_r[LAST] ? corr_r[LAST] : ZERO_D;
      result     = prod_r[LAST] - {out_corr_s, ZERO_D};
   end

   assign out_valid = valid_out_s;
   assign out_tag   = tag_r[LAST];
   assign inflight  = inflight_r;

`ifdef MULTIPLIER_OVERFLOW_FLAG_EN
   // top holds result bits [2*DATA_LEN-1 : DATA_LEN-1].
   function automatic logic ovf_calc(input logic [DATA_LEN:0] top, input logic sgn);
      logic ovf_v;
      if (sgn) begin
         ovf_v = ~((&top) | ~(|top));
      end else begin
         ovf_v = |top[DATA_LEN:1];
      end
      return ovf_v;
   endfunction

   logic [DATA_LEN-1:0] last_corr_s;
   logic [DATA_LEN:0]   last_top_s;
   logic                overflow_r;

   // Upper bits of the corrected product entering the last stage.
   always_comb begin
      last_corr_s = sign_next_s[LAST] ? corr_next_s[LAST] : ZERO_D;
      last_top_s  = {prod_next_s[LAST][PROD_W-1:DATA_LEN] - last_corr_s,
                     prod_next_s[LAST][DATA_LEN-1]};
   end

   // Flag is captured alongside the last stage so it stays aligned with result.
   always_ff @(posedge clk) begin
      if (!stall_s) begin
         overflow_r <= ovf_calc(last_top_s, sign_next_s[LAST]);
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign overflow = overflow_r;
`else
   assign overflow = 1'b0;
`endif

endmodule
